// File: rtl/addsub_sequencer.sv
// Control FSM for the signed accumulate datapath: A +/- B +/- C +/- D with skippable operands.
// Result after SETTLE_CYCLES*(1+enabled operands)+1 cycles; start ignored while busy, result held until ack.
module addsub_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op_en,
  input  logic [2:0] op_sub,
  input  logic       ack,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       addOrSub,
  output logic       done,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] step_count
);

  typedef enum logic [2:0] {IDLE, LOAD, STEP_B, STEP_C, STEP_D, FINISH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_en;
  logic [2:0] r_sub;
  logic       r_s0, r_s1, r_s2, r_aos, r_done, r_busy, r_rv;
  logic [1:0] r_step;
  state_t     w_nxt;

  // Next enabled operand after the current state, in B, C, D order.
  always_comb begin
    w_nxt = FINISH;
    case (r_state)
      LOAD:    w_nxt = r_en[0] ? STEP_B : r_en[1] ? STEP_C : r_en[2] ? STEP_D : FINISH;
      STEP_B:  w_nxt = r_en[1] ? STEP_C : r_en[2] ? STEP_D : FINISH;
      STEP_C:  w_nxt = r_en[2] ? STEP_D : FINISH;
      default: w_nxt = FINISH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= CNT_INIT;
      r_en    <= 3'b000;
      r_sub   <= 3'b000;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_aos   <= 1'b1;
      r_done  <= 1'b1;
      r_busy  <= 1'b0;
      r_rv    <= 1'b0;
      r_step  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_en    <= op_en;
            r_sub   <= op_sub;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_INIT;
            r_state <= LOAD;
          end
        end
        LOAD, STEP_B, STEP_C, STEP_D: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_state != LOAD) r_step <= r_step + 2'd1;
            r_cnt   <= CNT_INIT;
            r_state <= w_nxt;
            // Control word of the state being entered; FINISH keeps select and addOrSub.
            case (w_nxt)
              STEP_B: begin
                r_s0 <= 1'b1; r_done <= 1'b0; r_s2 <= 1'b0; r_s1 <= 1'b0; r_aos <= ~r_sub[0];
              end
              STEP_C: begin
                r_s0 <= 1'b1; r_done <= 1'b0; r_s2 <= 1'b0; r_s1 <= 1'b1; r_aos <= ~r_sub[1];
              end
              STEP_D: begin
                r_s0 <= 1'b1; r_done <= 1'b0; r_s2 <= 1'b1; r_s1 <= 1'b0; r_aos <= ~r_sub[2];
              end
              default: begin
                r_s0 <= 1'b1; r_done <= 1'b1; r_rv <= 1'b1;
              end
            endcase
          end
        end
        FINISH: begin
          if (ack) begin
            r_state <= IDLE;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_aos   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_rv    <= 1'b0;
            r_step  <= 2'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s0           = r_s0;
  assign s1           = r_s1;
  assign s2           = r_s2;
  assign addOrSub     = r_aos;
  assign done         = r_done;
  assign busy         = r_busy;
  assign result_valid = r_rv;
  assign step_count   = r_step;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Scoreboarded bench: directed operations against a behavioural accumulate datapath driven by the DUT controls.
module tb_addsub_sequencer;

  typedef struct {
    int res;
    int steps;
    int lat;
  } exp_t;
  typedef int iq_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op_en = 3'b000;
  logic [2:0] op_sub = 3'b000;
  logic       ack = 1'b0;
  logic       s0, s1, s2, addOrSub, done, busy, result_valid;
  logic [1:0] step_count;

  logic signed [7:0] dp_a = 8'sd0, dp_b = 8'sd0, dp_c = 8'sd0, dp_d = 8'sd0;
  logic signed [7:0] acc;
  logic [3:0]        prev_w = 4'd0;

  exp_t sb[$];
  iq_t  sel_q;
  iq_t  aos_q;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_rv = 1'b0;

  addsub_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .op_en(op_en), .op_sub(op_sub), .ack(ack),
    .s0(s0), .s1(s1), .s2(s2), .addOrSub(addOrSub), .done(done), .busy(busy),
    .result_valid(result_valid), .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Level-sensitive datapath: A loads while s0=0; one add/sub per control-word change while done=0.
  always @(posedge clock) begin
    logic signed [7:0] opnd;
    case ({s2, s1})
      2'b00:   opnd = dp_b;
      2'b01:   opnd = dp_c;
      2'b10:   opnd = dp_d;
      default: opnd = 8'sd0;
    endcase
    if (!s0) begin
      acc <= dp_a;
    end else if (!done && ({s2, s1, s0, done} != prev_w)) begin
      acc <= addOrSub ? acc + opnd : acc - opnd;
      sel_q.push_back(int'({s2, s1}));
      aos_q.push_back(int'(addOrSub));
      chk({s2, s1} != 2'b11, "illegal_select", int'({s2, s1}), 0);
    end
    prev_w <= {s2, s1, s0, done};
  end

  // Monitor: timestamps accepts, pops the scoreboard on each rising result_valid.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (busy && !prev_busy) acc_cyc = cyc;
    if (result_valid && !prev_rv) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_result", int'(acc), 0);
      end else begin
        e = sb.pop_front();
        chk(int'(acc) == e.res, "result", int'(acc), e.res);
        chk(int'(step_count) == e.steps, "step_count", int'(step_count), e.steps);
        chk(cyc - acc_cyc + 1 == e.lat, "latency", cyc - acc_cyc + 1, e.lat);
      end
    end
    prev_busy = busy;
    prev_rv = result_valid;
  end

  task automatic check_reset_vals(input string tag);
    chk(s0 == 1'b0, {tag, "_s0"}, int'(s0), 0);
    chk(s1 == 1'b0, {tag, "_s1"}, int'(s1), 0);
    chk(s2 == 1'b0, {tag, "_s2"}, int'(s2), 0);
    chk(addOrSub == 1'b1, {tag, "_addOrSub"}, int'(addOrSub), 1);
    chk(done == 1'b1, {tag, "_done"}, int'(done), 1);
    chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
    chk(result_valid == 1'b0, {tag, "_rv"}, int'(result_valid), 0);
    chk(step_count == 2'd0, {tag, "_step"}, int'(step_count), 0);
  endtask

  task automatic check_q(input string name, input iq_t got, input iq_t expv);
    chk(got.size() == expv.size(), {name, "_len"}, got.size(), expv.size());
    for (int i = 0; i < expv.size() && i < got.size(); i++)
      chk(got[i] == expv[i], name, got[i], expv[i]);
  endtask

  task automatic wait_rv(input int budget);
    int n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!result_valid) chk(1'b0, "rv_timeout", n, budget);
  endtask

  task automatic run_op(input int a, input int b, input int c, input int d,
                        input logic [2:0] en, input logic [2:0] sub,
                        input int exp_res, input int exp_lat, input int exp_steps, input int hold);
    dp_a = 8'(a); dp_b = 8'(b); dp_c = 8'(c); dp_d = 8'(d);
    sb.push_back('{exp_res, exp_steps, exp_lat});
    sel_q.delete();
    aos_q.delete();
    op_en = en; op_sub = sub; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    op_en = 3'($urandom_range(0, 7));
    op_sub = 3'($urandom_range(0, 7));
    wait_rv(40);
    repeat (hold) begin
      @(negedge clock);
      chk(result_valid == 1'b1, "rv_hold", int'(result_valid), 1);
      chk(int'(acc) == exp_res, "acc_hold", int'(acc), exp_res);
    end
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk(busy == 1'b0, "busy_after_ack", int'(busy), 0);
    chk(result_valid == 1'b0, "rv_after_ack", int'(result_valid), 0);
    chk(step_count == 2'd0, "step_after_ack", int'(step_count), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_vals("reset");

    // 1: all operands added
    run_op(10, 3, 5, 2, 3'b111, 3'b000, 20, 9, 3, 0);
    check_q("t1_sel", sel_q, '{0, 1, 2});
    check_q("t1_aos", aos_q, '{1, 1, 1});

    // 2: mixed subtract, result held across a late ack
    run_op(10, 3, 5, 2, 3'b111, 3'b101, 10, 9, 3, 5);
    check_q("t2_aos", aos_q, '{0, 1, 0});

    // 3: single C step, then no operands at all
    run_op(-7, 0, 4, 0, 3'b010, 3'b000, -3, 5, 1, 0);
    check_q("t3_sel", sel_q, '{1});
    run_op(-7, 0, 4, 0, 3'b000, 3'b000, -7, 3, 0, 0);
    chk(sel_q.size() == 0, "t3_no_steps", sel_q.size(), 0);

    // 4: 8-bit wrap
    run_op(100, 100, 0, 0, 3'b001, 3'b000, -56, 5, 1, 0);
    check_q("t4_sel", sel_q, '{0});

    // 5: start held high with changing config, then start+ack together
    dp_a = 8'sd10; dp_b = 8'sd3; dp_c = 8'sd5; dp_d = 8'sd2;
    sb.push_back('{20, 3, 9});
    op_en = 3'b111; op_sub = 3'b000; start = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      op_en = 3'($urandom_range(0, 7));
      op_sub = 3'($urandom_range(0, 7));
      n++;
    end while (!result_valid && n < 40);
    if (!result_valid) chk(1'b0, "t5_rv_timeout", n, 40);
    op_en = 3'b001; op_sub = 3'b001; ack = 1'b1;
    sb.push_back('{7, 1, 5});
    @(negedge clock);
    ack = 1'b0;
    chk(busy == 1'b0, "t5_idle_gap_busy", int'(busy), 0);
    chk(result_valid == 1'b0, "t5_idle_gap_rv", int'(result_valid), 0);
    @(negedge clock);
    start = 1'b0;
    chk(busy == 1'b1, "t5_reaccept", int'(busy), 1);
    wait_rv(40);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk(busy == 1'b0, "t5_busy_after_ack", int'(busy), 0);

    // 6: reset mid STEP_C, then a clean operation
    dp_a = 8'sd10; dp_b = 8'sd3; dp_c = 8'sd5; dp_d = 8'sd2;
    sb.push_back('{20, 3, 9});
    op_en = 3'b111; op_sub = 3'b000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(s1 && !done) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(s1 && !done, "t6_reach_step_c", int'(s1), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_vals("t6_reset");
    sb.delete();
    run_op(1, 1, 0, 0, 3'b001, 3'b000, 2, 5, 1, 0);

    repeat (3) @(negedge clock);
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
